mem_read_arbiter: RTL and testbench

Parametrised N-port read arbiter for the shared second port of the system memory. It generalises the two-port priority/secondary read controller to NUM_PORTS requesters.
- Port 0 can have strict priority (VGA); the other ports share round-robin.
- A starvation guard forces service of any waiting port after MAX_WAIT cycles.
- The arbiter tracks in-flight reads through a RD_LATENCY-deep tag pipeline, so each requester gets its own rd_valid pulse aligned with returning data.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_picker.sv | 28 ++
 rtl/mem_read_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_read_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-port memory read arbiter.
package mem_arb_pkg;

    // Wide enough for the largest supported arbiter (8 ports).
    localparam int IDX_W = 3;

    localparam logic PRIO_NONE  = 1'b0;
    localparam logic PRIO_PORT0 = 1'b1;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] port;
    } tag_t;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set mask bit after ptr, with wrap.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!any && mask[j] && (j == (int'(ptr) + k) % N)) begin
                    any     = 1'b1;
                    pick[j] = 1'b1;
                    idx     = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// N-port read arbiter for the shared memory read port, with starvation
// guard and a tag pipeline that routes returning data to its requester.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int RD_LATENCY     = 2,
    parameter int PRIORITY_PORT0 = 1,
    parameter int MAX_WAIT       = 15
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_rd_en,
    input  logic [DATA_W-1:0]           mem_rd_data,
    output logic [DATA_W-1:0]           rd_data,
    output logic [NUM_PORTS-1:0]        rd_valid
);

    localparam int IW  = idx_w(NUM_PORTS);
    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic PRIO = (PRIORITY_PORT0 != 0) ? PRIO_PORT0 : PRIO_NONE;
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_PORTS - 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);
    localparam logic [NUM_PORTS-1:0] P0_MASK =
        (PRIO == PRIO_PORT0) ? NUM_PORTS'(1) : '0;

    logic [IW-1:0]        rr_ptr;
    logic [WCW-1:0]       wait_cnt [NUM_PORTS];
    tag_t                 tag_pipe [RD_LATENCY+1];

    logic [NUM_PORTS-1:0] starved;
    logic [NUM_PORTS-1:0] rr_mask;
    logic [NUM_PORTS-1:0] s_pick;
    logic [NUM_PORTS-1:0] r_pick;
    logic [NUM_PORTS-1:0] pick;
    logic [IW-1:0]        s_idx;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        pick_idx;
    logic                 s_any;
    logic                 r_any;
    logic                 prio_hit;
    logic                 any_gnt;
    logic [ADDR_W-1:0]    sel_addr;

    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            starved[i] = req[i] && (wait_cnt[i] == WAIT_MAX);
        end
    end

    assign rr_mask  = req & ~P0_MASK;
    assign prio_hit = (PRIO == PRIO_PORT0) && req[0];

    rr_picker #(.N(NUM_PORTS), .IW(IW)) u_starve_pick (
        .mask (starved),
        .ptr  (rr_ptr),
        .pick (s_pick),
        .idx  (s_idx),
        .any  (s_any)
    );

    rr_picker #(.N(NUM_PORTS), .IW(IW)) u_rr_pick (
        .mask (rr_mask),
        .ptr  (rr_ptr),
        .pick (r_pick),
        .idx  (r_idx),
        .any  (r_any)
    );

    // Starvation overrides priority, priority overrides round-robin.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        if (s_any) begin
            pick     = s_pick;
            pick_idx = s_idx;
        end else if (prio_hit) begin
            pick     = NUM_PORTS'(1);
            pick_idx = '0;
        end else if (r_any) begin
            pick     = r_pick;
            pick_idx = r_idx;
        end
    end

    assign gnt     = reset_n ? pick : '0;
    assign any_gnt = |pick;

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick[i]) sel_addr = addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= PTR_RST;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) wait_cnt[i] <= '0;
        end else begin
            mem_rd_en <= any_gnt;
            if (any_gnt) mem_addr <= sel_addr;
            if (s_any) begin
                rr_ptr <= s_idx;
            end else if (!prio_hit && r_any) begin
                rr_ptr <= r_idx;
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (i == 0 && PRIO == PRIO_PORT0) begin
                    wait_cnt[i] <= '0;
                end else if (req[i] && !pick[i]) begin
                    if (wait_cnt[i] != WAIT_MAX) begin
                        wait_cnt[i] <= wait_cnt[i] + WCW'(1);
                    end
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end

    // Stage 0 lines up with mem_rd_en; the last stage with returning data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= RD_LATENCY; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: any_gnt, port: IDX_W'(pick_idx)};
            for (int k = 1; k <= RD_LATENCY; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    always_comb begin
        rd_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (tag_pipe[RD_LATENCY].valid &&
                tag_pipe[RD_LATENCY].port == IDX_W'(i)) begin
                rd_valid[i] = 1'b1;
            end
        end
    end

    assign rd_data = mem_rd_data;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed vectors plus a randomized run
// against a cycle-level reference model.
module tb_mem_read_arbiter;

    localparam int LAT = 2;
    localparam int MW  = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [71:0] addr;
    logic [3:0]  gnt;
    logic [17:0] mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rd_data;
    logic [15:0] rd_data;
    logic [3:0]  rd_valid;

    logic [1:0]  req2;
    logic [35:0] addr2;
    logic [1:0]  gnt2;
    logic [17:0] maddr2;
    logic        en2;
    logic [15:0] mdata2;
    logic [15:0] rdata2;
    logic [1:0]  rv2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_read_arbiter #(
        .NUM_PORTS(4), .ADDR_W(18), .DATA_W(16), .RD_LATENCY(LAT),
        .PRIORITY_PORT0(1), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .gnt(gnt),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rd_data(mem_rd_data), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    mem_read_arbiter #(
        .NUM_PORTS(2), .ADDR_W(18), .DATA_W(16), .RD_LATENCY(1),
        .PRIORITY_PORT0(0), .MAX_WAIT(2)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .req(req2), .addr(addr2), .gnt(gnt2),
        .mem_addr(maddr2), .mem_rd_en(en2),
        .mem_rd_data(mdata2), .rd_data(rdata2), .rd_valid(rv2)
    );

    function automatic logic [15:0] mem_fn(input logic [17:0] a);
        return a[15:0] ^ {a[17:16], 14'h01A5};
    endfunction

    function automatic logic [17:0] pa(input int i);
        return 18'h00100 + 18'(i) * 18'h01000;
    endfunction

    // Memory model: data for the address presented with mem_rd_en
    // appears LAT cycles later.
    logic [17:0] mp0, mp1;
    always @(posedge clk) begin
        mp0 <= mem_addr;
        mp1 <= mp0;
    end
    assign mem_rd_data = mem_fn(mp1);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic [3:0]  rv;
        logic        en;
        logic [17:0] ma;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] r, input logic [3:0] g,
                       input logic [3:0] v, input logic e,
                       input logic [17:0] a);
        vec_t x;
        x.req = r; x.gnt = g; x.rv = v; x.en = e; x.ma = a;
        tbl.push_back(x);
    endtask

    // Reference model state
    int          rr_m;
    int          waitc [4];
    logic        m_en;
    logic [17:0] m_addr;
    int          sp [16];
    logic [17:0] sa [16];
    logic [17:0] ra [4];
    logic [3:0]  pend;
    int          g;
    int          slot;
    int          port;

    function automatic int model_pick(input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            int p = (rr_m + k) % 4;
            if (p != 0 && r[p] && waitc[p] >= MW) return p;
        end
        if (r[0]) return 0;
        for (int k = 1; k <= 4; k++) begin
            int p = (rr_m + k) % 4;
            if (p != 0 && r[p]) return p;
        end
        return -1;
    endfunction

    initial begin
        reset_n = 1'b0;
        req     = '0;
        addr    = '0;
        req2    = '0;
        addr2   = {18'h15555, 18'h0AAAA};
        mdata2  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_en", 32'(mem_rd_en), 0);
        chk("rst_maddr", 32'(mem_addr), 0);
        chk("rst_rv", 32'(rd_valid), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // idle
        add(4'b0000, 4'b0000, 4'b0000, 0, 18'h0);
        add(4'b0000, 4'b0000, 4'b0000, 0, 18'h0);
        // single priority read
        add(4'b0001, 4'b0001, 4'b0000, 0, 18'h0);
        add(4'b0000, 4'b0000, 4'b0000, 1, 18'h00100);
        add(4'b0000, 4'b0000, 4'b0000, 0, 18'h0);
        add(4'b0000, 4'b0000, 4'b0001, 0, 18'h0);
        // round-robin over ports 1..3
        add(4'b1110, 4'b0010, 4'b0000, 0, 18'h0);
        add(4'b1110, 4'b0100, 4'b0000, 1, 18'h01100);
        add(4'b1110, 4'b1000, 4'b0000, 1, 18'h02100);
        add(4'b1110, 4'b0010, 4'b0010, 1, 18'h03100);
        add(4'b1110, 4'b0100, 4'b0100, 1, 18'h01100);
        add(4'b1110, 4'b1000, 4'b1000, 1, 18'h02100);
        add(4'b0000, 4'b0000, 4'b0010, 1, 18'h03100);
        add(4'b0000, 4'b0000, 4'b0100, 0, 18'h0);
        add(4'b0000, 4'b0000, 4'b1000, 0, 18'h0);
        // priority vs starvation of port 2
        add(4'b0101, 4'b0001, 4'b0000, 0, 18'h0);
        add(4'b0101, 4'b0001, 4'b0000, 1, 18'h00100);
        add(4'b0101, 4'b0001, 4'b0000, 1, 18'h00100);
        add(4'b0101, 4'b0100, 4'b0001, 1, 18'h00100);
        add(4'b0101, 4'b0001, 4'b0001, 1, 18'h02100);
        add(4'b0101, 4'b0001, 4'b0001, 1, 18'h00100);
        add(4'b0101, 4'b0001, 4'b0100, 1, 18'h00100);
        add(4'b0101, 4'b0100, 4'b0001, 1, 18'h00100);
        add(4'b0000, 4'b0000, 4'b0001, 1, 18'h02100);
        add(4'b0000, 4'b0000, 4'b0001, 0, 18'h0);
        add(4'b0000, 4'b0000, 4'b0100, 0, 18'h0);

        addr = {pa(3), pa(2), pa(1), pa(0)};
        foreach (tbl[n]) begin
            req = tbl[n].req;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", n), 32'(gnt), 32'(tbl[n].gnt));
            chk($sformatf("tbl%0d_rv", n), 32'(rd_valid), 32'(tbl[n].rv));
            chk($sformatf("tbl%0d_en", n), 32'(mem_rd_en), 32'(tbl[n].en));
            if (tbl[n].en)
                chk($sformatf("tbl%0d_ma", n), 32'(mem_addr), 32'(tbl[n].ma));
            if (tbl[n].rv != 0) begin
                port = 0;
                for (int j = 0; j < 4; j++) if (tbl[n].rv[j]) port = j;
                chk($sformatf("tbl%0d_data", n), 32'(rd_data),
                    32'(mem_fn(pa(port))));
            end
            @(posedge clk); #1;
        end

        // two-port instance, port 0 in round-robin: strict alternation
        for (int k = 0; k < 9; k++) begin
            req2   = (k < 6) ? 2'b11 : 2'b00;
            mdata2 = 16'hBE00 + 16'(k);
            @(negedge clk);
            chk("p2_gnt", 32'(gnt2),
                (k < 6) ? ((k % 2 == 0) ? 32'd1 : 32'd2) : 32'd0);
            chk("p2_rv", 32'(rv2),
                (k >= 2 && k < 8) ? (((k - 2) % 2 == 0) ? 32'd1 : 32'd2)
                                  : 32'd0);
            chk("p2_en", 32'(en2), (k >= 1 && k <= 6) ? 32'd1 : 32'd0);
            if (k >= 1 && k <= 6)
                chk("p2_ma", 32'(maddr2),
                    ((k - 1) % 2 == 0) ? 32'h0AAAA : 32'h15555);
            chk("p2_data", 32'(rdata2), 32'(mdata2));
            @(posedge clk); #1;
        end

        // reads in flight to ports 1 and 2, then asynchronous reset
        req = 4'b0010;
        @(negedge clk);
        chk("fl_gnt1", 32'(gnt), 32'h2);
        @(posedge clk); #1;
        req = 4'b0100;
        @(negedge clk);
        chk("fl_gnt2", 32'(gnt), 32'h4);
        @(posedge clk); #1;
        req = 4'b0001;
        #2;
        chk("fl_en", 32'(mem_rd_en), 1);
        reset_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_en", 32'(mem_rd_en), 0);
        chk("arst_maddr", 32'(mem_addr), 0);
        chk("arst_rv", 32'(rd_valid), 0);
        @(posedge clk); @(posedge clk); #1;
        req = '0;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_rst_rv", 32'(rd_valid), 0);
            chk("post_rst_en", 32'(mem_rd_en), 0);
            @(posedge clk); #1;
        end

        // randomized traffic against the reference model
        rr_m   = 3;
        m_en   = 1'b0;
        m_addr = '0;
        pend   = '0;
        for (int i = 0; i < 4; i++) begin
            waitc[i] = 0;
            ra[i]    = '0;
        end
        for (int i = 0; i < 16; i++) begin
            sp[i] = -1;
            sa[i] = '0;
        end
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 55) begin
                    pend[i] = 1'b1;
                    ra[i]   = 18'($urandom);
                end
            end
            req  = pend;
            addr = {ra[3], ra[2], ra[1], ra[0]};
            @(negedge clk);
            g = model_pick(pend);
            chk("rnd_gnt", 32'(gnt), (g < 0) ? 32'd0 : (32'd1 << g));
            chk("rnd_en", 32'(mem_rd_en), 32'(m_en));
            chk("rnd_maddr", 32'(mem_addr), 32'(m_addr));
            slot = c % 16;
            chk("rnd_rv", 32'(rd_valid),
                (sp[slot] < 0) ? 32'd0 : (32'd1 << sp[slot]));
            if (sp[slot] >= 0)
                chk("rnd_data", 32'(rd_data), 32'(mem_fn(sa[slot])));
            sp[slot] = -1;
            chk("rnd_wait1", 32'(dut.wait_cnt[1]), 32'(waitc[1]));
            chk("rnd_wait2", 32'(dut.wait_cnt[2]), 32'(waitc[2]));
            chk("rnd_wait3", 32'(dut.wait_cnt[3]), 32'(waitc[3]));

            m_en = (g >= 0);
            if (g >= 0) begin
                m_addr = ra[g];
                sp[(c + 1 + LAT) % 16] = g;
                sa[(c + 1 + LAT) % 16] = ra[g];
            end
            for (int i = 1; i < 4; i++) begin
                if (pend[i] && i != g)
                    waitc[i] = (waitc[i] < MW) ? waitc[i] + 1 : MW;
                else
                    waitc[i] = 0;
            end
            if (g > 0) rr_m = g;
            if (g >= 0) pend[g] = 1'b0;
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
